mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose these parameters: ADDR_W, 16, memory address width; DATA_W, 8, memory data width.
REQ-002 The block SHALL have these ports: clk  input  1  system clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-005 cpu_we  input  1  1 = write, 0 = read; stable while cpu_req.
REQ-006 cpu_addr  input  ADDR_W  CPU address; stable while cpu_req.
REQ-007 cpu_wdata  input  DATA_W  CPU write data; stable while cpu_req.
REQ-008 cpu_rdata  output  DATA_W  read data, valid in the cpu_ack cycle and held afterwards.
REQ-009 cpu_ack  output  1  one-cycle completion pulse.
REQ-010 dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack SHALL mirror the six CPU ports for the DMA/loader requester.
REQ-011 mem_dir  output  ADDR_W  address to main memory.
REQ-012 mem_datos  inout  DATA_W  bidirectional memory data bus.
REQ-013 mem_le  output  1  read/write strobe: 1 = read/idle, memory writes on falling edge.
REQ-014 grant_dma  output  1  1 while the current or last access belongs to DMA.

Function
REQ-015 The FSM SHALL have states IDLE, RD, WR_SETUP, WR_STROBE, WR_RECOVER, DONE.
REQ-016 In IDLE, when any req is high, the arbiter SHALL latch the winner's we/addr/wdata and go to RD (we=0) or WR_SETUP (we=1).
REQ-017 If both requests are high in IDLE, the requester not granted last SHALL win (round-robin); a lone requester SHALL always win.
REQ-018 RD: mem_le=1, mem_dir=latched addr, mem_datos high-Z; at the end of RD, mem_datos SHALL be captured into the winner's rdata; next state DONE.
REQ-019 WR_SETUP: mem_le=1, mem_dir and mem_datos driven with latched addr/wdata; next state WR_STROBE.
REQ-020 WR_STROBE: mem_le=0, with addr and data still driven; next state WR_RECOVER.
REQ-021 WR_RECOVER: mem_le=1, with addr and data still driven; next state DONE.
REQ-022 DONE: the winner's ack SHALL be 1 for exactly this cycle, mem_datos high-Z; next state IDLE.
REQ-023 Latency from req sampled in IDLE to ack SHALL be 2 cycles for a read and 4 cycles for a write.
REQ-024 mem_datos SHALL be driven only in WR_SETUP, WR_STROBE and WR_RECOVER.
REQ-025 mem_le SHALL be 0 only in WR_STROBE, giving exactly one falling edge per write.
REQ-026 A request still high in IDLE after its ack SHALL be treated as a new access; requesters drop req in the cycle after ack.
REQ-027 In IDLE, mem_dir SHALL hold its last value and mem_le SHALL be 1.
REQ-028 The non-winning requester's rdata and ack SHALL be unaffected by the access.
REQ-029 Changes to req inputs outside IDLE SHALL be ignored until the next IDLE.

Reset
REQ-030 When reset_n is low, the block SHALL asynchronously enter IDLE with mem_le=1, mem_datos high-Z, mem_dir=0, both acks 0, both rdata 0, and grant_dma=1 so that the CPU wins the first contention.
REQ-031 Reset during WR_STROBE SHALL drive mem_le to 1 immediately; because this is a rising edge, no write SHALL occur.
REQ-032 Reset during any other state SHALL produce no falling edge on mem_le.

Structure
REQ-033 State encoding and the ADDR_W/DATA_W defaults SHALL live in the shared package mem_arb_pkg.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last; output grant[1:0]).
REQ-035 The FSM and tristate control SHALL remain in mem_arbiter.

Verification
REQ-036 CPU read of 0x0000 holding 0xA5 -> mem_le stays 1, cpu_ack 2 cycles later, cpu_rdata=0xA5.
REQ-037 DMA write of 0x2F to 0xFF00 -> exactly one mem_le low cycle with mem_dir=0xFF00 and mem_datos=0x2F; dma_ack 4 cycles later; a subsequent CPU read of 0xFF00 returns 0x2F.
REQ-038 cpu_req and dma_req both rise in the same cycle after reset -> CPU served first, then DMA; with both held, grants alternate CPU, DMA, CPU.
REQ-039 reset_n asserted during WR_STROBE of a write 0x77 to 0x0010 (prior content 0x00) -> mem_le returns to 1 asynchronously, no ack, 0x0010 still reads 0x00.
REQ-040 Back-to-back CPU reads of 0x0001 then 0x0002 -> an IDLE cycle separates the accesses, each ack is one cycle wide, and mem_datos is never driven by the arbiter.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: default widths and FSM encoding.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD         = 3'd1,
    WR_SETUP   = 3'd2,
    WR_STROBE  = 3'd3,
    WR_RECOVER = 3'd4,
    DONE       = 3'd5
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. Bit 0 is the CPU and bit 1 is the DMA.
// When both request, the side that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and DMA requesters onto one asynchronous SRAM-style port.
// Writes use setup/strobe/recover phases, so each write gives exactly one low pulse on mem_le.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_dir,
  inout  wire  [DATA_W-1:0] mem_datos,
  output logic              mem_le,
  output logic              grant_dma
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  arb_state_e  state_q, state_d;
  req_t        cpu_in, dma_in, lat_q, lat_d;
  logic        last_q, last_d;
  logic [1:0]  grant;
  logic        le_q, oe_q;
  logic        cpu_ack_q, dma_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

  assign cpu_in = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dma_in = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};

  rr_arbiter2 u_rr (
    .req   ({dma_req, cpu_req}),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          last_d  = grant[1];
          lat_d   = grant[1] ? dma_in : cpu_in;
          state_d = lat_d.we ? WR_SETUP : RD;
        end
      end
      RD:         state_d = DONE;
      WR_SETUP:   state_d = WR_STROBE;
      WR_STROBE:  state_d = WR_RECOVER;
      WR_RECOVER: state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Bus controls are registered from the next state so mem_le and the
  // data enable never glitch; the async reset forces mem_le high at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      lat_q       <= '0;
      le_q        <= 1'b1;
      oe_q        <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      lat_q     <= lat_d;
      le_q      <= (state_d != WR_STROBE);
      oe_q      <= state_d inside {WR_SETUP, WR_STROBE, WR_RECOVER};
      cpu_ack_q <= (state_d == DONE) && !last_d;
      dma_ack_q <= (state_d == DONE) &&  last_d;
      if (state_q == RD) begin
        if (last_q) dma_rdata_q <= mem_datos;
        else        cpu_rdata_q <= mem_datos;
      end
    end
  end

  assign mem_datos = oe_q ? lat_q.wdata : {DATA_W{1'bz}};
  assign mem_dir   = lat_q.addr;
  assign mem_le    = le_q;
  assign grant_dma = last_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural SRAM that commits on the
// clock falling edge while mem_le is low.
module tb_mem_arbiter;

  logic        clk, reset_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
  logic        cpu_ack, dma_ack, mem_le, grant_dma;
  logic [15:0] mem_dir;
  wire  [7:0]  mem_datos;

  logic        mem_oe;
  logic [7:0]  mem_arr [0:65535];
  int          low_cnt, drv_cnt;
  logic [15:0] low_dir;
  logic [7:0]  low_dat;
  int          errs, checks;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_dir(mem_dir), .mem_datos(mem_datos), .mem_le(mem_le), .grant_dma(grant_dma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_datos = mem_oe ? mem_arr[mem_dir] : 8'hzz;

  // Memory model and bus observer share one process so mem_arr has a single writer.
  initial begin
    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'h00;
    mem_arr[0] = 8'hA5;
    mem_arr[1] = 8'h11;
    mem_arr[2] = 8'h22;
    low_cnt = 0;
    drv_cnt = 0;
    low_dir = '0;
    low_dat = '0;
    forever begin
      @(negedge clk);
      if (dut.oe_q) drv_cnt++;
      if (!mem_le) begin
        low_cnt++;
        low_dir = mem_dir;
        low_dat = mem_datos;
        mem_arr[mem_dir] = mem_datos;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on either port; req drops as soon as ack is seen.
  task automatic acc(input bit dma, input logic we, input logic [15:0] a,
                     input logic [7:0] d, output int lat);
    lat = 0;
    if (dma) begin
      dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    end
    do begin
      tick();
      lat++;
    end while (!(dma ? dma_ack : cpu_ack) && lat < 20);
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  initial begin
    int lat, base_low, base_drv;
    logic [1:0] exp_ack;
    errs = 0; checks = 0;
    reset_n = 1'b0; mem_oe = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    #12;
    chk("rst_le",    mem_le,    1);
    chk("rst_dir",   mem_dir,   0);
    chk("rst_acks",  {cpu_ack, dma_ack}, 0);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    chk("rst_gdma",  grant_dma, 1);
    @(negedge clk) reset_n = 1'b1;
    tick();

    // Contention straight after reset: CPU, DMA, CPU with both held.
    mem_oe = 1'b1;
    cpu_we = 0; cpu_addr = 16'h0001;
    dma_we = 0; dma_addr = 16'h0002;
    cpu_req = 1; dma_req = 1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_ack = (n == 2 || n == 8) ? 2'b10 : (n == 5) ? 2'b01 : 2'b00;
      chk("cont_ack", {cpu_ack, dma_ack}, exp_ack);
      if (n == 2) chk("cont_g0", grant_dma, 0);
      if (n == 5) chk("cont_g1", grant_dma, 1);
    end
    cpu_req = 0; dma_req = 0;
    chk("cont_crd", cpu_rdata, 8'h11);
    chk("cont_drd", dma_rdata, 8'h22);
    tick();

    // CPU read of 0x0000.
    base_low = low_cnt;
    acc(0, 0, 16'h0000, 8'h00, lat);
    chk("rd0_lat",   lat, 2);
    chk("rd0_data",  cpu_rdata, 8'hA5);
    chk("rd0_dack",  dma_ack, 0);
    chk("rd0_drd",   dma_rdata, 8'h22);
    tick();
    chk("rd0_hold",  cpu_rdata, 8'hA5);
    chk("rd0_nolow", low_cnt - base_low, 0);

    // DMA write 0x2F to 0xFF00, then CPU reads it back.
    mem_oe = 1'b0;
    base_low = low_cnt; base_drv = drv_cnt;
    acc(1, 1, 16'hFF00, 8'h2F, lat);
    chk("wr_lat",  lat, 4);
    chk("wr_gdma", grant_dma, 1);
    chk("wr_cack", cpu_ack, 0);
    tick();
    chk("wr_lows", low_cnt - base_low, 1);
    chk("wr_dir",  low_dir, 16'hFF00);
    chk("wr_dat",  low_dat, 8'h2F);
    chk("wr_drv",  drv_cnt - base_drv, 3);
    mem_oe = 1'b1;
    acc(0, 0, 16'hFF00, 8'h00, lat);
    chk("rb_lat",  lat, 2);
    chk("rb_data", cpu_rdata, 8'h2F);
    chk("rb_gdma", grant_dma, 0);
    tick();

    // Back-to-back CPU reads with req held; an IDLE cycle must separate them.
    base_drv = drv_cnt;
    cpu_we = 0; cpu_addr = 16'h0001; cpu_req = 1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("b2b_ack", cpu_ack, (n == 2 || n == 5) ? 1 : 0);
      if (n == 2) begin
        chk("b2b_rd1", cpu_rdata, 8'h11);
        cpu_addr = 16'h0002;
      end
    end
    cpu_req = 0;
    chk("b2b_rd2", cpu_rdata, 8'h22);
    tick();
    chk("b2b_nodrv", drv_cnt - base_drv, 0);

    // Reset in the middle of the write strobe must abort the write.
    mem_oe = 1'b0;
    base_low = low_cnt;
    cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 8'h77; cpu_req = 1;
    tick();
    tick();
    chk("rs_strobe", mem_le, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("rs_le",   mem_le, 1);
    chk("rs_ack",  cpu_ack, 0);
    chk("rs_dir",  mem_dir, 0);
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    #1;
    chk("rs_nowr", mem_arr[16'h0010], 8'h00);
    chk("rs_lows", low_cnt - base_low, 0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    mem_oe = 1'b1;
    acc(0, 0, 16'h0010, 8'h00, lat);
    chk("rs_rblat", lat, 2);
    chk("rs_rb",    cpu_rdata, 8'h00);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timed out");
  end

endmodule
